// File: rtl/niosmp_pio_pkg.sv
// -----------------------------------------------------------------------------
// niosmp_pio_pkg
//   Shared definitions for the niosmp edge-capture input PIO.
//   - Register addresses for the 2-bit Avalon-MM word address.
//   - Edge-type encodings used by the EDGE_TYPE parameter.
//   - Small helper for the per-bit edge function.
// -----------------------------------------------------------------------------
package niosmp_pio_pkg;

  // Register map (word addresses)
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  // EDGE_TYPE encodings
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Per-bit edge function on 32-bit vectors; callers slice down to WIDTH.
  // Unknown encodings fall back to "any" so no edge is ever silently dropped.
  function automatic logic [31:0] edge_bits(input logic [31:0] cur,
                                            input logic [31:0] prev,
                                            input int          edge_type);
    logic [31:0] res;
    res = '0;
    case (edge_type)
      EDGE_RISE: res = cur & ~prev;
      EDGE_FALL: res = ~cur & prev;
      default:   res = cur ^ prev;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/niosmp_rnw_in_if.sv
// -----------------------------------------------------------------------------
// niosmp_rnw_in_if
//   Avalon-MM slave bus bundle for the edge-capture input PIO.
//   Signals:
//     address    [1:0]  word register select
//     chipselect        slave select
//     write_n           active-low write strobe
//     writedata  [31:0] write data
//     readdata   [31:0] registered read data
//   Handshake: there is no wait-request. A write is accepted in any cycle
//   where chipselect && !write_n; it takes effect at that clock edge. Read data
//   is fixed-latency: readdata in cycle N+1 reflects the address presented in
//   cycle N, independent of chipselect, and reads have no side effects.
// -----------------------------------------------------------------------------
interface niosmp_rnw_in_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/niosmp_sync_edge.sv
// -----------------------------------------------------------------------------
// niosmp_sync_edge
//   Brings an asynchronous WIDTH-bit input into the clk domain through a
//   SYNC_STAGES-deep flop chain, keeps a one-cycle-delayed copy (in_prev) and
//   produces single-cycle per-bit edge pulses of the selected EDGE_TYPE.
//   Ports:
//     clk        in   system clock
//     reset_n    in   asynchronous active-low reset
//     in_port    in   [WIDTH-1:0] asynchronous external input
//     in_sync    out  [WIDTH-1:0] synchronized input
//     edge_pulse out  [WIDTH-1:0] one-cycle edge pulses
// -----------------------------------------------------------------------------
module niosmp_sync_edge
  import niosmp_pio_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_ANY
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] in_sync,
  output logic [WIDTH-1:0] edge_pulse
);

  // The chain and in_prev reset to 0, which is not a real sample of the line.
  // arm_q walks a 1 through SYNC_STAGES+1 flops so edges are only reported
  // once both in_sync and in_prev hold genuine post-reset samples; otherwise a
  // line held high across reset would look like a rising edge.
  localparam int ARM_LEN = SYNC_STAGES + 1;

  logic [WIDTH-1:0]   sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]   in_prev;
  logic [ARM_LEN-1:0] arm_q;
  logic               armed;

  logic [31:0] cur_ext;
  logic [31:0] prev_ext;
  logic [31:0] edge_ext;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      in_prev <= '0;
      arm_q   <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      in_prev <= in_sync;
      arm_q   <= {arm_q[ARM_LEN-2:0], 1'b1};
    end
  end

  assign in_sync = sync_q[SYNC_STAGES-1];
  assign armed   = arm_q[ARM_LEN-1];

  // Widen to 32 bits for the shared helper; works for WIDTH up to 32.
  always_comb begin
    cur_ext                = '0;
    prev_ext               = '0;
    cur_ext[WIDTH-1:0]     = in_sync;
    prev_ext[WIDTH-1:0]    = in_prev;
    edge_ext               = edge_bits(cur_ext, prev_ext, EDGE_TYPE);
  end

  assign edge_pulse = armed ? edge_ext[WIDTH-1:0] : '0;

endmodule

// File: rtl/niosmp_rnw_in.sv
// -----------------------------------------------------------------------------
// niosmp_rnw_in
//   Avalon-MM slave input port with edge capture: receive-side partner of the
//   single-bit PIO driving the async-comms read/not-write line. Synchronizes
//   in_port, detects per-bit edges, latches them into a sticky edge_capture
//   register and raises a maskable level interrupt.
//   Ports:
//     clk      in   system clock
//     reset_n  in   asynchronous active-low reset
//     avs      slave modport of niosmp_rnw_in_if (address, chipselect,
//              write_n, writedata, registered readdata)
//     in_port  in   [WIDTH-1:0] asynchronous external input
//     irq      out  active-high level interrupt
//   Register map:
//     0 data          RO  synchronized input, zero-extended
//     1 reserved      RO  reads 0
//     2 irq_mask      RW  WIDTH bits
//     3 edge_capture  R/W1C sticky edge bits (set wins over a same-cycle clear)
//   Parameters: WIDTH 1..32, EDGE_TYPE 0 rise / 1 fall / 2 any, SYNC_STAGES 2..3.
// -----------------------------------------------------------------------------
module niosmp_rnw_in
  import niosmp_pio_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int EDGE_TYPE   = EDGE_ANY,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  niosmp_rnw_in_if.slave   avs,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] edge_pulse;

  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] edge_capture_next;
  logic [WIDTH-1:0] clr_bits;

  logic             wr_en;
  logic             wr_mask;
  logic             wr_cap;
  logic [31:0]      rd_mux;

  // Only the low WIDTH bits of writedata are architecturally meaningful.
  logic             unused_wdata;
  assign unused_wdata = ^{1'b0, avs.writedata};

  // ---------------------------------------------------------------------------
  // Synchronizer and edge detection
  // ---------------------------------------------------------------------------
  niosmp_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync_edge (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_port    (in_port),
    .in_sync    (in_sync),
    .edge_pulse (edge_pulse)
  );

  // ---------------------------------------------------------------------------
  // Write decode
  // ---------------------------------------------------------------------------
  assign wr_en   = avs.chipselect && !avs.write_n;
  assign wr_mask = wr_en && (avs.address == ADDR_IRQMASK);
  assign wr_cap  = wr_en && (avs.address == ADDR_EDGECAP);

  // ---------------------------------------------------------------------------
  // irq_mask
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
    end else if (wr_mask) begin
      irq_mask <= avs.writedata[WIDTH-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // edge_capture: clear first, then OR in new edges so a same-cycle edge on a
  // bit being cleared keeps that bit set and no event is lost.
  // ---------------------------------------------------------------------------
  always_comb begin
    clr_bits          = '0;
    if (wr_cap) begin
      clr_bits = avs.writedata[WIDTH-1:0];
    end
    edge_capture_next = (edge_capture & ~clr_bits) | edge_pulse;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture <= '0;
    end else begin
      edge_capture <= edge_capture_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path: registered every cycle from the current address, so a read
  // concurrent with a register write returns the pre-write value.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_mux = '0;
    case (avs.address)
      ADDR_DATA:    rd_mux[WIDTH-1:0] = in_sync;
      ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edge_capture;
      default:      rd_mux            = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs.readdata <= '0;
    end else begin
      avs.readdata <= rd_mux;
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt: derived purely from flops, so it is glitch-free.
  // ---------------------------------------------------------------------------
  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_niosmp_rnw_in.sv
// -----------------------------------------------------------------------------
// tb_niosmp_rnw_in
//   Drives two instances of niosmp_rnw_in (WIDTH=8, SYNC_STAGES=2) from the
//   same bus and input line: one capturing rising edges, one capturing any
//   edge. Read expectations are queued when a read is issued and compared
//   when readdata returns one cycle later.
// -----------------------------------------------------------------------------
module tb_niosmp_rnw_in;
  import niosmp_pio_pkg::*;

  localparam int WIDTH = 8;
  localparam int SYNC  = 2;

  // ---------------------------------------------------------------------------
  // Clock and reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Stimulus signals, shared by both instances
  // ---------------------------------------------------------------------------
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [WIDTH-1:0] in_port;
  logic             irq_rise;
  logic             irq_any;

  niosmp_rnw_in_if bus_rise ();
  niosmp_rnw_in_if bus_any ();

  assign bus_rise.address    = address;
  assign bus_rise.chipselect = chipselect;
  assign bus_rise.write_n    = write_n;
  assign bus_rise.writedata  = writedata;
  assign bus_any.address     = address;
  assign bus_any.chipselect  = chipselect;
  assign bus_any.write_n     = write_n;
  assign bus_any.writedata   = writedata;

  niosmp_rnw_in #(
    .WIDTH       (WIDTH),
    .EDGE_TYPE   (EDGE_RISE),
    .SYNC_STAGES (SYNC)
  ) u_dut_rise (
    .clk     (clk),
    .reset_n (reset_n),
    .avs     (bus_rise),
    .in_port (in_port),
    .irq     (irq_rise)
  );

  niosmp_rnw_in #(
    .WIDTH       (WIDTH),
    .EDGE_TYPE   (EDGE_ANY),
    .SYNC_STAGES (SYNC)
  ) u_dut_any (
    .clk     (clk),
    .reset_n (reset_n),
    .avs     (bus_any),
    .in_port (in_port),
    .irq     (irq_any)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [63:0] exp_q[$];   // {expected rise-instance, expected any-instance}

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_irq(input string tag, input logic exp_r, input logic exp_a);
    check_val({tag, "_rise"}, {31'b0, irq_rise}, {31'b0, exp_r});
    check_val({tag, "_any"},  {31'b0, irq_any},  {31'b0, exp_a});
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change and outputs are sampled on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_read(input string tag, input logic [1:0] a,
                          input logic [31:0] exp_r, input logic [31:0] exp_a);
    logic [63:0] e;
    @(negedge clk);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    exp_q.push_back({exp_r, exp_a});
    @(negedge clk);
    chipselect = 1'b0;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s: expected queue empty", tag);
    end else begin
      e = exp_q.pop_front();
      check_val({tag, "_rise"}, bus_rise.readdata, e[63:32]);
      check_val({tag, "_any"},  bus_any.readdata,  e[31:0]);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int cnt;
    address    = ADDR_DATA;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 8'hA5;
    reset_n    = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idle(6);

    // Reset state: line held at 0xA5 across release produces no captures
    check_irq("rst_irq", 1'b0, 1'b0);
    bus_read("rst_data", ADDR_DATA,    32'h0000_00A5, 32'h0000_00A5);
    bus_read("rst_cap",  ADDR_EDGECAP, 32'h0,         32'h0);
    bus_read("rst_mask", ADDR_IRQMASK, 32'h0,         32'h0);

    // Falling on the 0xA5 bits: only the any-edge instance captures
    @(negedge clk);
    in_port = 8'h00;
    idle(5);
    bus_read("fall_cap", ADDR_EDGECAP, 32'h0, 32'h0000_00A5);
    check_irq("fall_irq_masked", 1'b0, 1'b0);
    bus_write(ADDR_EDGECAP, 32'h0000_00FF);
    bus_read("clr_all", ADDR_EDGECAP, 32'h0, 32'h0);

    // Rising capture with irq
    bus_write(ADDR_IRQMASK, 32'h0000_0001);
    @(negedge clk);
    in_port = 8'h01;
    cnt = 0;
    while (!irq_rise && cnt < SYNC + 2) begin
      @(negedge clk);
      cnt++;
    end
    check_irq("rise_irq", 1'b1, 1'b1);
    bus_read("rise_cap", ADDR_EDGECAP, 32'h1, 32'h1);
    @(negedge clk);
    in_port = 8'h00;
    idle(5);
    bus_read("fall_nochg", ADDR_EDGECAP, 32'h1, 32'h1);
    bus_write(ADDR_EDGECAP, 32'h0000_0001);
    check_irq("clr_irq", 1'b0, 1'b0);
    bus_read("clr_cap", ADDR_EDGECAP, 32'h0, 32'h0);

    // Masking
    bus_write(ADDR_IRQMASK, 32'h0);
    @(negedge clk);
    in_port = 8'h08;
    idle(5);
    bus_read("mask_cap", ADDR_EDGECAP, 32'h8, 32'h8);
    check_irq("masked_irq", 1'b0, 1'b0);
    bus_write(ADDR_IRQMASK, 32'h0000_0008);
    check_irq("unmask_irq", 1'b1, 1'b1);

    // Set/clear race on bit2: the edge pulse lands in the write cycle
    @(negedge clk);
    in_port = 8'h0C;
    @(negedge clk);
    bus_write(ADDR_EDGECAP, 32'h0000_0004);
    idle(3);
    bus_read("race_cap", ADDR_EDGECAP, 32'h0000_000C, 32'h0000_000C);

    // Width and reserved/data write behaviour
    bus_write(ADDR_IRQMASK, 32'hFFFF_FFFF);
    bus_read("mask_width", ADDR_IRQMASK, 32'h0000_00FF, 32'h0000_00FF);
    bus_write(ADDR_RSVD, 32'hFFFF_FFFF);
    bus_read("rsvd", ADDR_RSVD, 32'h0, 32'h0);
    bus_write(ADDR_DATA, 32'h0);
    bus_read("data", ADDR_DATA, 32'h0000_000C, 32'h0000_000C);

    // Reset mid-operation with all bits captured and unmasked
    @(negedge clk);
    in_port = 8'h00;
    idle(5);
    bus_write(ADDR_EDGECAP, 32'h0000_00FF);
    bus_read("pre_rst_clr", ADDR_EDGECAP, 32'h0, 32'h0);
    @(negedge clk);
    in_port = 8'hFF;
    idle(5);
    check_irq("pre_rst_irq", 1'b1, 1'b1);
    bus_read("pre_rst_cap", ADDR_EDGECAP, 32'h0000_00FF, 32'h0000_00FF);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_irq("async_irq", 1'b0, 1'b0);
    check_val("async_rdata_rise", bus_rise.readdata, 32'h0);
    check_val("async_rdata_any",  bus_any.readdata,  32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(6);
    check_irq("post_rst_irq", 1'b0, 1'b0);
    bus_read("post_rst_cap",  ADDR_EDGECAP, 32'h0,         32'h0);
    bus_read("post_rst_mask", ADDR_IRQMASK, 32'h0,         32'h0);
    bus_read("post_rst_data", ADDR_DATA,    32'h0000_00FF, 32'h0000_00FF);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/niosmp_rnw_in.md
Name: niosmp_rnw_in

Overview:
- Avalon-MM slave input port with edge capture. It is the receive-side counterpart of the single-bit output-port PIO that drives the async-comms read/not-write line.
- Samples an external WIDTH-bit line into the clk domain through a synchronizer and detects edges per bit.
- Latches detected edges into a sticky capture register and raises a maskable interrupt to the Nios II.

Parameters:
- WIDTH, 1, number of input bits (1..32).
- EDGE_TYPE, 2, edge to capture: 0 = rising, 1 = falling, 2 = any.
- SYNC_STAGES, 2, synchronizer depth (2..3).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- address  input  2  register select
- chipselect  input  1  slave select
- write_n  input  1  active-low write strobe
- writedata  input  32  write data
- readdata  output  32  read data, registered
- in_port  input  WIDTH  asynchronous external input
- irq  output  1  interrupt request, active-high, level

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. On reset, all synchronizer flops, the previous-value flop, irq_mask, edge_capture and readdata are 0, so irq is 0. Reset asserted mid-operation clears pending captures immediately; after release there are no edges until the first post-reset transition.
- Synchronizer: in_port passes through SYNC_STAGES flops to give in_sync.
  - in_prev is in_sync delayed one clk.
  - in_sync is visible at address 0 SYNC_STAGES cycles after a stable input change.
- Edge detect, per bit:
  - rising: in_sync & ~in_prev
  - falling: ~in_sync & in_prev
  - any: in_sync ^ in_prev
  - Each edge is a single-cycle pulse.
- Register map (address, read / write):
  - 0 data: read returns in_sync zero-extended; write ignored.
  - 1 reserved: read returns 0; write ignored.
  - 2 irq_mask: read/write WIDTH bits from writedata[WIDTH-1:0]; upper bits read 0.
  - 3 edge_capture: read returns sticky bits. A write with writedata bit i = 1 clears bit i; bit i = 0 leaves it unchanged.
- Write qualifier: chipselect && ~write_n.
- Simultaneous edge and clear on the same bit in the same cycle: set wins, so the bit stays 1 and no event is lost.
- Repeated edges while a bit is already set: the bit stays 1 (no count).
- Read path: every clk, readdata <= the mux output for the current address, so read latency is exactly 1 cycle.
  - Reads have no side effects; reading edge_capture does not clear it.
  - Because readdata is registered every cycle, a read in the same cycle as a write to irq_mask or edge_capture returns the pre-write value.
- irq: combinational OR-reduce of (edge_capture & irq_mask), driven only from flops.
  - Asserts the cycle after the capture bit sets, given the mask bit is 1.
  - Deasserts the cycle after the clear or mask write.
- Enabling a mask bit while its capture bit is already 1 raises irq on the next cycle.
- Widths: writedata[31:WIDTH] is ignored; readdata[31:WIDTH] is always 0.

Decomposition:
- Package niosmp_pio_pkg holds:
  - address constants: ADDR_DATA = 0, ADDR_RSVD = 1, ADDR_IRQMASK = 2, ADDR_EDGECAP = 3
  - EDGE_TYPE encodings: EDGE_RISE = 0, EDGE_FALL = 1, EDGE_ANY = 2
- Sub-module niosmp_sync_edge, parameterized by WIDTH, SYNC_STAGES and EDGE_TYPE:
  - holds the synchronizer chain, in_prev and the edge-pulse logic
  - outputs in_sync and edge_pulse[WIDTH-1:0]
- The top level keeps the registers, read mux and irq.

Test Plan:
- Reset value check: WIDTH = 8, EDGE_TYPE = 2. Hold in_port = 0xA5 across reset release, with no further change. Read address 0 → 0x000000A5; read address 3 → 0x00000000; irq = 0.
- Rising capture with irq, EDGE_TYPE = 0:
  - Write 0x01 to address 2, then drive in_port bit0 0→1. edge_capture = 0x01 and irq = 1 within SYNC_STAGES + 2 cycles. Drive bit0 1→0: no change.
  - Write 0x01 to address 3: irq drops the next cycle; read address 3 → 0.
- Masking: edge on bit3 with mask = 0x00 → edge_capture = 0x08, irq stays 0. Write mask 0x08 → irq = 1 the next cycle.
- Set/clear race: pulse an edge on bit2 in the same cycle as a write of 0x04 to address 3 → edge_capture bit2 remains 1.
- Read latency and width: write 0xFFFFFFFF to address 2, WIDTH = 8. Readdata is valid 1 cycle after address 2 is presented and equals 0x000000FF; read address 1 → 0.
- Reset mid-operation: capture 0xFF with mask 0xFF and irq = 1, then pulse reset_n low for 1 cycle. irq and edge_capture drop to 0 asynchronously; the mask reads 0 after reset.
